dmem_port_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters:
  - port 0: the pipelined processor's load/store stage.
  - port 1: a secondary master, such as a debug/dump engine or memory loader.
- Port 0 has fixed priority. A starvation counter forces a grant to port 1 after a bounded wait.
- Memory-side command signals are registered, giving one command per cycle to dmem. Read data is returned to the winner with a valid strobe.

---
 rtl/dmem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// +------------------------------------------------------------------------+
// | Module  : dmem_port_arbiter                                            |
// | Brief   : Two-port fixed-priority data-memory arbiter with starvation  |
// |           guard for port 1 and registered command issue to dmem.       |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module dmem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 3
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [1:0]        p0_size,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [1:0]        p1_size,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Buses travel whole, so the codebase's MSB-is-bit-0 labelling does not
    // change any value seen here.
    localparam logic [CNT_W-1:0] c_max_wait = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    logic              w_p0_gnt;
    logic              w_p1_gnt;
    logic              w_any_gnt;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [1:0]        w_sel_size;
    logic              w_sel_we;

    logic [CNT_W-1:0]  r_wait_cnt;
    logic              r_owner;
    logic              r_rd_valid;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [1:0]        r_mem_size;
    logic              r_mem_we;

    // Port 1 takes contended cycles only once it has waited MAX_WAIT times.
    always_comb begin
        w_p0_gnt = 1'b0;
        w_p1_gnt = 1'b0;
        if (rst) begin
            if (p1_req && (!p0_req || (r_wait_cnt >= c_max_wait))) begin
                w_p1_gnt = 1'b1;
            end else if (p0_req) begin
                w_p0_gnt = 1'b1;
            end
        end
    end

    assign w_any_gnt   = w_p0_gnt | w_p1_gnt;
    assign w_sel_addr  = w_p1_gnt ? p1_addr  : p0_addr;
    assign w_sel_wdata = w_p1_gnt ? p1_wdata : p0_wdata;
    assign w_sel_size  = w_p1_gnt ? p1_size  : p0_size;
    assign w_sel_we    = w_p1_gnt ? p1_we    : p0_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= '0;
        end else if (p1_req && !w_p1_gnt) begin
            r_wait_cnt <= (r_wait_cnt >= c_max_wait) ? c_max_wait
                                                     : r_wait_cnt + c_one;
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Strobes are single-cycle; address/data/size hold across idle cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_size  <= '0;
            r_mem_we    <= 1'b0;
            r_owner     <= 1'b0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_mem_we   <= 1'b0;
            r_rd_valid <= 1'b0;
            if (w_any_gnt) begin
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
                r_mem_size  <= w_sel_size;
                r_mem_we    <= w_sel_we;
                r_owner     <= w_p1_gnt;
                r_rd_valid  <= ~w_sel_we;
            end
        end
    end

    assign p0_gnt    = w_p0_gnt;
    assign p1_gnt    = w_p1_gnt;
    assign p0_rvalid = r_rd_valid & ~r_owner;
    assign p1_rvalid = r_rd_valid &  r_owner;
    assign p0_rdata  = mem_rdata;
    assign p1_rdata  = mem_rdata;

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_size  = r_mem_size;
    assign mem_we    = r_mem_we;

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// +------------------------------------------------------------------------+
// | Module  : tb_dmem_port_arbiter                                         |
// | Brief   : Self-checking bench for dmem_port_arbiter with a word memory |
// |           and a transaction-level reference model.                     |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_port_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0;
    logic [1:0]  p0_size = '0;
    logic        p0_gnt, p0_rvalid;
    logic [31:0] p0_rdata;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p1_addr = '0, p1_wdata = '0;
    logic [1:0]  p1_size = '0;
    logic        p1_gnt, p1_rvalid;
    logic [31:0] p1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [1:0]  mem_size;

    dmem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT), .CNT_W(3)
    ) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_size(p0_size), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_size(p1_size), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_size(mem_size), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Word-wide data memory: combinational read, write at posedge.
    logic [31:0] dmem [0:255];
    logic [31:0] refm [0:255];
    assign mem_rdata = dmem[mem_addr[9:2]];
    always @(posedge clk) if (mem_we) dmem[mem_addr[9:2]] <= mem_wdata;

    // Reference model: command expected on the memory side this cycle.
    logic        m_we, m_rv0, m_rv1;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  m_size;
    int          losses;
    logic        exp_g0, exp_g1;
    logic        obs_g0, obs_g1, obs_we, obs_rv0, obs_rv1;
    logic [31:0] obs_addr, obs_rd0, obs_rd1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_we = 1'b0; m_rv0 = 1'b0; m_rv1 = 1'b0;
        m_addr = '0; m_wdata = '0; m_size = '0;
        losses = 0;
    endtask

    task automatic set_p0(input logic req, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] s);
        p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d; p0_size = s;
    endtask

    task automatic set_p1(input logic req, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] s);
        p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d; p1_size = s;
    endtask

    // One clock cycle: inputs are already driven; check at negedge, advance model at posedge.
    task automatic cycle();
        exp_g0 = 1'b0;
        exp_g1 = 1'b0;
        if (rst) begin
            if (p0_req && p1_req) begin
                if (losses >= MAX_WAIT) exp_g1 = 1'b1;
                else                    exp_g0 = 1'b1;
            end else begin
                exp_g0 = p0_req;
                exp_g1 = p1_req;
            end
        end
        @(negedge clk);
        obs_g0 = p0_gnt; obs_g1 = p1_gnt; obs_we = mem_we; obs_addr = mem_addr;
        obs_rv0 = p0_rvalid; obs_rv1 = p1_rvalid; obs_rd0 = p0_rdata; obs_rd1 = p1_rdata;
        check("p0_gnt", 32'(p0_gnt), 32'(exp_g0));
        check("p1_gnt", 32'(p1_gnt), 32'(exp_g1));
        check("mem_we", 32'(mem_we), 32'(m_we));
        check("p0_rvalid", 32'(p0_rvalid), 32'(m_rv0));
        check("p1_rvalid", 32'(p1_rvalid), 32'(m_rv1));
        check("mem_addr", mem_addr, m_addr);
        check("mem_wdata", mem_wdata, m_wdata);
        check("mem_size", 32'(mem_size), 32'(m_size));
        if (m_rv0) check("p0_rdata", p0_rdata, refm[m_addr[9:2]]);
        if (m_rv1) check("p1_rdata", p1_rdata, refm[m_addr[9:2]]);
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            if (m_we) refm[m_addr[9:2]] = m_wdata;
            m_we = 1'b0; m_rv0 = 1'b0; m_rv1 = 1'b0;
            if (exp_g0 || exp_g1) begin
                m_addr  = exp_g1 ? p1_addr  : p0_addr;
                m_wdata = exp_g1 ? p1_wdata : p0_wdata;
                m_size  = exp_g1 ? p1_size  : p0_size;
                m_we    = exp_g1 ? p1_we    : p0_we;
                m_rv0   = exp_g0 && !p0_we;
                m_rv1   = exp_g1 && !p1_we;
            end
            if (p1_req && !exp_g1) losses = (losses + 1 > MAX_WAIT) ? MAX_WAIT : losses + 1;
            else                   losses = 0;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            refm[i] = $urandom;
            dmem[i] = refm[i];
        end
        refm[1] = 32'h0BAD_F00D; dmem[1] = 32'h0BAD_F00D;
        refm[2] = 32'hCAFE_1234; dmem[2] = 32'hCAFE_1234;
        refm[8] = 32'hA5A5_0F0F; dmem[8] = 32'hA5A5_0F0F;
        model_reset();

        // Reset held with both ports requesting
        p0_req = 1'b1; p1_req = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("rst_p0_gnt", 32'(p0_gnt), 32'd0);
        check("rst_p1_gnt", 32'(p1_gnt), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        @(posedge clk); #1;
        cycle();
        rst = 1'b1;
        cycle();
        check("rel_p0_gnt", 32'(obs_g0), 32'd1);
        set_p0(0, 0, 0, 0, 0); set_p1(0, 0, 0, 0, 0);
        cycle();

        // Port 0 write then read-back
        set_p0(1, 1, 32'h2000, 32'hDEAD_BEEF, 2'b11);
        cycle();
        check("wr_gnt", 32'(obs_g0), 32'd1);
        set_p0(1, 0, 32'h2000, 32'h0, 2'b11);
        cycle();
        check("wr_mem_we", 32'(obs_we), 32'd1);
        check("wr_mem_addr", obs_addr, 32'h2000);
        set_p0(0, 0, 0, 0, 0);
        cycle();
        check("raw_rvalid", 32'(obs_rv0), 32'd1);
        check("raw_rdata", obs_rd0, 32'hDEAD_BEEF);

        // Continuous contention: port 1 wins every fifth cycle
        set_p0(1, 0, 32'h2040, 0, 2'b11);
        set_p1(1, 0, 32'h2044, 0, 2'b11);
        for (int i = 0; i < 15; i++) begin
            cycle();
            check("starve_p1_gnt", 32'(obs_g1), 32'(i % 5 == 4));
        end
        set_p0(0, 0, 0, 0, 0); set_p1(0, 0, 0, 0, 0);
        cycle();

        // Owner tagging of back-to-back reads
        set_p0(1, 0, 32'h2004, 0, 2'b11);
        cycle();
        set_p0(0, 0, 0, 0, 0);
        set_p1(1, 0, 32'h2008, 0, 2'b11);
        cycle();
        check("own_rv0_n1", 32'(obs_rv0), 32'd1);
        check("own_rv1_n1", 32'(obs_rv1), 32'd0);
        check("own_rd0", obs_rd0, 32'h0BAD_F00D);
        set_p1(0, 0, 0, 0, 0);
        cycle();
        check("own_rv0_n2", 32'(obs_rv0), 32'd0);
        check("own_rv1_n2", 32'(obs_rv1), 32'd1);
        check("own_rd1", obs_rd1, 32'hCAFE_1234);

        // Idle hold after one write grant
        set_p0(1, 1, 32'h2010, 32'h0000_55AA, 2'b11);
        cycle();
        set_p0(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("idle_addr", obs_addr, 32'h2010);
            if (i > 0) check("idle_we", 32'(obs_we), 32'd0);
            check("idle_rv", 32'({obs_rv0, obs_rv1}), 32'd0);
        end

        // Reset lands while a port 1 write is on the memory port
        set_p1(1, 1, 32'h2020, 32'h1234_5678, 2'b11);
        cycle();
        set_p1(0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        check("mrst_mem_we", 32'(mem_we), 32'd0);
        check("mrst_rvalid", 32'({p0_rvalid, p1_rvalid}), 32'd0);
        model_reset();
        cycle();
        rst = 1'b1;
        set_p0(1, 0, 32'h2020, 0, 2'b11);
        cycle();
        set_p0(0, 0, 0, 0, 0);
        cycle();
        check("mrst_old_rv", 32'(obs_rv0), 32'd1);
        check("mrst_old_data", obs_rd0, 32'hA5A5_0F0F);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            set_p0(($urandom % 4) != 0, $urandom % 2, 32'h2000 + (($urandom % 64) << 2),
                   $urandom, 2'($urandom));
            set_p1(($urandom % 3) != 0, $urandom % 2, 32'h2000 + (($urandom % 64) << 2),
                   $urandom, 2'($urandom));
            cycle();
        end
        set_p0(0, 0, 0, 0, 0); set_p1(0, 0, 0, 0, 0);
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
